mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Multi-cycle data-memory access stage between the ALU and the write-back selector. It accepts one load or store request per transaction and drives a synchronous single-port data RAM (one-cycle read latency) with word address, byte-lane write enables and lane-replicated store data. It returns sign- or zero-extended load data as the DRAM_rd operand of write-back, with a one-cycle response strobe. Misaligned accesses are optionally trapped.

## Interface
- ADDR_W, 16, word-address width of the data RAM
- clk  in  1  clock; every state change on the rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  stage can accept; high only in IDLE with rst low
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address from ALU_C
- req_wdata  in  32  store data (rs2)
- dram_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2]
- dram_re  out  1  read strobe
- dram_we  out  4  byte-lane write enables, bit i = byte i
- dram_wdata  out  32  lane-replicated store data
- dram_rdata  in  32  RAM read word, valid the cycle after dram_re
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data to write-back; 0 for stores and traps
- rsp_misalign  out  1  qualifies rsp_valid: access was trapped

## Operation
- FSM states: IDLE, RD_WAIT, RESP. Reset → IDLE.
- IDLE, req_valid=1 (accept): load → dram_re=1, go RD_WAIT; store → dram_we/dram_wdata driven, go RESP; trapped → no RAM strobe, go RESP with misalign flag captured.
- RD_WAIT: align/extend dram_rdata by captured addr[1:0] and funct3, register into rsp_rdata, go RESP.
- RESP: rsp_valid=1, then IDLE. Write-back never stalls; no rsp_ready.
- Load extraction: B/BU lane addr[1:0]; H/HU lane addr[1] (bytes 1:0 or 3:2); W whole word. B/H sign-extend, BU/HU zero-extend.
- Store: SB wdata={4{b}}, we=0001<<addr[1:0]; SH wdata={2{h}}, we=addr[1]?1100:0011; SW we=1111.
- Undefined funct3 (011, 110, 111, or 100/101 on a store) is treated as W.
- RAM strobes are combinational from the request and asserted only in the accept cycle; zero otherwise.

## Timing
- Reset values: req_ready=0 during rst, rsp_valid=0, rsp_rdata=0, rsp_misalign=0, dram_re=0, dram_we=0000, dram_wdata=0, dram_addr=0.
- Load accepted cycle N: dram_re at N, dram_rdata sampled at end of N+1, rsp_valid at N+2.
- Store accepted cycle N: write at edge ending N, rsp_valid at N+1.
- Throughput: one load per 3 cycles, one store per 2; req_ready=0 in RD_WAIT and RESP.
- rst asserted in any state: next state IDLE, pending response dropped, no rsp_valid, no further RAM strobe.
- req_valid held during RD_WAIT/RESP is not sampled.

## Configuration
- MEM_MISALIGN_CHK_EN defined: H with addr[0]=1 or W with addr[1:0]≠00 is trapped (no RAM access, rsp_valid with rsp_misalign=1 at N+1, rsp_rdata=0).
- Undefined: rsp_misalign tied 0; W ignores addr[1:0]; H uses addr[1] only.

## Structure
- Shared package mem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state enum, lane-enable constants.
- One sub-module: load_align (combinational extract + extend from word, addr[1:0], funct3), reusable by a later pipelined variant.

## Test plan
- Store SW 0xDEADBEEF @0x10, then LW @0x10 → dram_we=1111 at N; load rsp_valid at N+2 with rsp_rdata=0xDEADBEEF.
- SB 0x80 @0x13, LB @0x13 → dram_we=1000, dram_wdata=0x80808080; rsp_rdata=0xFFFFFF80; LBU → 0x00000080.
- SH 0x8001 @0x22, LH/LHU @0x22 → dram_we=1100; rsp_rdata 0xFFFF8001 / 0x00008001.
- With MEM_MISALIGN_CHK_EN: LW @0x11 → no dram_re, rsp_valid at N+1, rsp_misalign=1, rsp_rdata=0; undefined: reads word 0x10.
- rst pulsed in RD_WAIT → no rsp_valid, req_ready=1 cycle after rst drops, next LW completes normally.
- Back-to-back req_valid held high → accepts spaced 3 cycles (loads) / 2 cycles (stores), never two RAM strobes in consecutive cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access stage: RV32I funct3 codes,
// FSM states, byte-lane enables and the access-size decode.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] LANE_B0   = 4'b0001;
    localparam logic [3:0] LANE_H_LO = 4'b0011;
    localparam logic [3:0] LANE_H_HI = 4'b1100;
    localparam logic [3:0] LANE_W    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    // Any code without a defined meaning for the access direction is a word access.
    function automatic size_t access_size(input logic we, input logic [2:0] funct3);
        size_t sz;
        case (funct3)
            F3_B:    sz = SZ_B;
            F3_H:    sz = SZ_H;
            F3_BU:   sz = we ? SZ_W : SZ_B;
            F3_HU:   sz = we ? SZ_W : SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request / response / data-RAM bundle of the memory access stage.
// master = requester (ALU side), slave = access unit, mem = data RAM.
interface mem_access_unit_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;

    logic [ADDR_W-1:0] dram_addr;
    logic              dram_re;
    logic [3:0]        dram_we;
    logic [31:0]       dram_wdata;
    logic [31:0]       dram_rdata;

    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_misalign;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_misalign
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, dram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_misalign,
               dram_addr, dram_re, dram_we, dram_wdata
    );

    modport mem (
        input  dram_addr, dram_re, dram_we, dram_wdata,
        output dram_rdata
    );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// load_align: pure combinational lane extraction and sign/zero extension of a
// RAM word, selected by the byte offset and the funct3 width code.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = word;
        case (access_size(1'b0, funct3))
            SZ_B:    data = funct3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    data = funct3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store stage driving a 1-cycle-latency single-port data RAM.
// Define MEM_MISALIGN_CHK_EN to trap misaligned halfword/word accesses.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  bus
);

    state_t      state;
    logic [1:0]  addr_lo_q;
    logic [2:0]  funct3_q;
    logic        misalign_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic [31:0] load_data;

    logic  accept;
    logic  req_trap;
    size_t req_size;

    assign bus.req_ready = (state == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign req_size      = access_size(bus.req_we, bus.req_funct3);

`ifdef MEM_MISALIGN_CHK_EN
    assign req_trap = ((req_size == SZ_H) && bus.req_addr[0]) ||
                      ((req_size == SZ_W) && (bus.req_addr[1:0] != 2'b00));
`else
    assign req_trap = 1'b0;
`endif

    // Address bits above the RAM and the halfword/word low bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+2];

    // RAM strobes live only in the accept cycle so a held request can never re-fire.
    always_comb begin
        bus.dram_addr  = '0;
        bus.dram_re    = 1'b0;
        bus.dram_we    = 4'b0000;
        bus.dram_wdata = '0;
        if (accept) begin
            bus.dram_addr = bus.req_addr[ADDR_W+1:2];
            if (!req_trap) begin
                if (bus.req_we) begin
                    case (req_size)
                        SZ_B: begin
                            bus.dram_we    = LANE_B0 << bus.req_addr[1:0];
                            bus.dram_wdata = {4{bus.req_wdata[7:0]}};
                        end
                        SZ_H: begin
                            bus.dram_we    = bus.req_addr[1] ? LANE_H_HI : LANE_H_LO;
                            bus.dram_wdata = {2{bus.req_wdata[15:0]}};
                        end
                        default: begin
                            bus.dram_we    = LANE_W;
                            bus.dram_wdata = bus.req_wdata;
                        end
                    endcase
                end else begin
                    bus.dram_re = 1'b1;
                end
            end
        end
    end

    load_align u_load_align (
        .word    (bus.dram_rdata),
        .addr_lo (addr_lo_q),
        .funct3  (funct3_q),
        .data    (load_data)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_lo_q   <= 2'b00;
            funct3_q    <= 3'b000;
            misalign_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_lo_q   <= bus.req_addr[1:0];
                        funct3_q    <= bus.req_funct3;
                        misalign_q  <= req_trap;
                        rsp_rdata_q <= '0;
                        if (!bus.req_we && !req_trap) begin
                            state <= RD_WAIT;
                        end else begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    rsp_rdata_q <= load_data;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.rsp_misalign = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// loads/stores against a byte-array memory model.
module tb_mem_access_unit;

    localparam int ADDR_W = 16;
`ifdef MEM_MISALIGN_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Synchronous single-port data RAM, one-cycle read latency, 64 words used.
    logic [31:0] ram [0:63];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (bus.dram_we[i]) ram[bus.dram_addr[5:0]][8*i +: 8] <= bus.dram_wdata[8*i +: 8];
        if (bus.dram_re) bus.dram_rdata <= ram[bus.dram_addr[5:0]];
    end

    // Reference memory: plain byte array, byte address 0..255.
    logic [7:0] ref_mem [0:255];

    function automatic int size_of(input bit we, input logic [2:0] f3);
        if (we) return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic int lane_off(input int sz, input logic [31:0] a);
        if (sz == 1) return int'(a[1:0]);
        if (sz == 2) return a[1] ? 2 : 0;
        return 0;
    endfunction

    function automatic bit traps(input int sz, input logic [31:0] a);
        return CHK_EN && ((sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00));
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(1'b0, f3);
        int base = int'(a[7:0]) & ~3;
        int off = lane_off(sz, a);
        logic [31:0] v = '0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[base + off + i]) << (8 * i));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    // Strobe monitor: no RAM strobe outside an accept cycle, never two in a row.
    bit prev_strobe = 1'b0;
    always @(negedge clk) begin
        bit cur;
        #2;
        cur = bus.dram_re || (bus.dram_we != 4'b0000);
        if (!(bus.req_valid && bus.req_ready)) check("stray_strobe", {27'b0, bus.dram_re, bus.dram_we}, 32'h0);
        if (cur) check("strobe_gap", {31'b0, prev_strobe}, 32'h0);
        prev_strobe = cur;
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, bus.req_ready}, 32'h1);
    endtask

    task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold);
        int sz = size_of(we, f3);
        int off = lane_off(sz, a);
        int base = int'(a[7:0]) & ~3;
        bit trap = traps(sz, a);
        logic [3:0] exp_we = '0;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        int exp_lat;
        int k;

        wait_ready("ready_idle");
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        #1;
        for (int i = 0; i < sz; i++) exp_we[off + i] = 1'b1;
        exp_wd = (sz == 1) ? 32'(wd[7:0]) * 32'h0101_0101 :
                 (sz == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
        exp_rd = (we || trap) ? 32'h0 : ref_load(f3, a);
        exp_lat = (!we && !trap) ? 2 : 1;

        if (trap) begin
            check("trap_re", {31'b0, bus.dram_re}, 32'h0);
            check("trap_we", {28'b0, bus.dram_we}, 32'h0);
        end else if (we) begin
            check("st_addr", 32'(bus.dram_addr), 32'(a[17:2]));
            check("st_we", {28'b0, bus.dram_we}, {28'b0, exp_we});
            check("st_wdata", bus.dram_wdata, exp_wd);
            check("st_re", {31'b0, bus.dram_re}, 32'h0);
        end else begin
            check("ld_addr", 32'(bus.dram_addr), 32'(a[17:2]));
            check("ld_re", {31'b0, bus.dram_re}, 32'h1);
            check("ld_we", {28'b0, bus.dram_we}, 32'h0);
        end

        @(posedge clk);
        #1;
        if (hold) begin
            bus.req_we     = $urandom_range(0, 1);
            bus.req_funct3 = 3'($urandom_range(0, 7));
            bus.req_addr   = $urandom_range(0, 255);
            bus.req_wdata  = $urandom;
        end else begin
            bus.req_valid = 1'b0;
        end
        if (we && !trap)
            for (int i = 0; i < sz; i++) ref_mem[base + off + i] = wd[8*i +: 8];

        for (k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid) break;
            check("busy_ready", {31'b0, bus.req_ready}, 32'h0);
        end
        bus.req_valid = 1'b0;
        check("latency", k, exp_lat);
        check("rsp_rdata", bus.rsp_rdata, exp_rd);
        check("rsp_misalign", {31'b0, bus.rsp_misalign}, {31'b0, trap});
        @(negedge clk);
        #1;
        check("rsp_pulse", {31'b0, bus.rsp_valid}, 32'h0);
    endtask

    task automatic b2b(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int gap, input int n_exp);
        int last = -1;
        int n_acc = 0;
        wait_ready("b2b_ready");
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (bus.req_ready) begin
                if (last >= 0) check("b2b_gap", c - last, gap);
                last = c;
                n_acc++;
            end
        end
        bus.req_valid = 1'b0;
        check("b2b_count", n_acc, n_exp);
        if (we)
            for (int i = 0; i < 4; i++) ref_mem[(int'(a[7:0]) & ~3) + i] = wd[8*i +: 8];
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            ram[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        bus.dram_rdata = '0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h40;
        #1;
        check("rst_ready", {31'b0, bus.req_ready}, 32'h0);
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_misalign", {31'b0, bus.rsp_misalign}, 32'h0);
        check("rst_dram_re", {31'b0, bus.dram_re}, 32'h0);
        check("rst_dram_we", {28'b0, bus.dram_we}, 32'h0);
        check("rst_dram_wdata", bus.dram_wdata, 32'h0);
        check("rst_dram_addr", 32'(bus.dram_addr), 32'h0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        txn(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0);
        txn(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        txn(1'b1, 3'b000, 32'h13, 32'h0000_0080, 1'b0);
        txn(1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
        txn(1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
        txn(1'b1, 3'b001, 32'h22, 32'h0000_8001, 1'b0);
        txn(1'b0, 3'b001, 32'h22, 32'h0, 1'b0);
        txn(1'b0, 3'b101, 32'h22, 32'h0, 1'b0);
        txn(1'b0, 3'b010, 32'h11, 32'h0, 1'b0);
        txn(1'b0, 3'b001, 32'h23, 32'h0, 1'b0);
        txn(1'b1, 3'b101, 32'h31, 32'h1234_5678, 1'b0);
        txn(1'b0, 3'b111, 32'h30, 32'h0, 1'b0);

        // Reset pulsed while a load sits in RD_WAIT.
        wait_ready("rst_ld_ready");
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h10;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rdwait_rst_ready", {31'b0, bus.req_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rdwait_rst_rsp", {31'b0, bus.rsp_valid}, 32'h0);
        check("rdwait_rst_idle", {31'b0, bus.req_ready}, 32'h1);
        @(negedge clk);
        #1;
        check("rdwait_rst_rsp2", {31'b0, bus.rsp_valid}, 32'h0);
        txn(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);

        // Request held high: loads every 3 cycles, stores every 2.
        b2b(1'b0, 3'b010, 32'h20, 32'h0, 3, 4);
        b2b(1'b1, 3'b010, 32'h24, 32'hCAFE_F00D, 2, 6);
        txn(1'b0, 3'b010, 32'h24, 32'h0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFC_0000) | 32'($urandom_range(0, 255));
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
